// File: rtl/sbox_arbiter_pkg.sv
// Shared AES definitions for the S-box arbiter: grant encoding, state/word types and
// byte-lane index helpers.
package sbox_arbiter_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef logic         gnt_t;

    localparam gnt_t GNT_A = 1'b0;
    localparam gnt_t GNT_B = 1'b1;

    localparam int unsigned NUM_LANES = 16;

    function automatic int unsigned lane_lsb(input int unsigned lane);
        return lane * 8;
    endfunction

    function automatic logic [7:0] get_lane(input state_t s, input int unsigned lane);
        return s[lane_lsb(lane) +: 8];
    endfunction

endpackage

// File: rtl/sbox_arbiter_sbox.sv
// 128-bit combinational AES SubBytes: sixteen independent byte lanes, each computed as
// the GF(2^8) multiplicative inverse followed by the AES affine transform.
module sbox_arbiter_sbox
    import sbox_arbiter_pkg::*;
(
    input  state_t data_i,
    output state_t data_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc ^= p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign data_o[lane_lsb(i) +: 8] = sbox_byte(get_lane(data_i, i));
    end

endmodule

// File: rtl/sbox_arbiter.sv
// Shares one SubBytes unit between the round datapath (A) and key-expansion SubWord (B),
// with per-cycle arbitration and one registered response slot per requester.
module sbox_arbiter
    import sbox_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a_valid,
    output logic         req_a_ready,
    input  logic [127:0] req_a_data,
    input  logic         req_b_valid,
    output logic         req_b_ready,
    input  logic [31:0]  req_b_data,
    output logic         rsp_a_valid,
    input  logic         rsp_a_ready,
    output logic [127:0] rsp_a_data,
    output logic         rsp_b_valid,
    input  logic         rsp_b_ready,
    output logic [31:0]  rsp_b_data
);

    logic   rsp_a_valid_q, rsp_a_valid_d;
    logic   rsp_b_valid_q, rsp_b_valid_d;
    state_t rsp_a_data_q, rsp_a_data_d;
    word_t  rsp_b_data_q, rsp_b_data_d;
    gnt_t   last_q, last_d;
    gnt_t   sel_q, sel_d;

    logic   elig_a, elig_b, cand_a, cand_b, gnt_a, gnt_b;
    state_t sbox_in, sbox_out;

    always_comb begin
        elig_a = !rsp_a_valid_q || rsp_a_ready;
        elig_b = !rsp_b_valid_q || rsp_b_ready;
        cand_a = req_a_valid && elig_a;
        cand_b = req_b_valid && elig_b;
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        if (cand_a && cand_b) begin
            if (PRIO_MODE != 0 || last_q == GNT_B) gnt_a = 1'b1;
            else                                   gnt_b = 1'b1;
        end else begin
            gnt_a = cand_a;
            gnt_b = cand_b;
        end
    end

    assign req_a_ready = gnt_a;
    assign req_b_ready = gnt_b;

    // Idle cycles keep the previous mux selection so the S-box input does not toggle.
    always_comb begin
        sel_d = sel_q;
        if (gnt_a)      sel_d = GNT_A;
        else if (gnt_b) sel_d = GNT_B;
        sbox_in = (sel_d == GNT_A) ? req_a_data : {96'b0, req_b_data};
    end

    sbox_arbiter_sbox u_sbox (
        .data_i (sbox_in),
        .data_o (sbox_out)
    );

    always_comb begin
        last_d        = last_q;
        rsp_a_valid_d = rsp_a_valid_q;
        rsp_b_valid_d = rsp_b_valid_q;
        rsp_a_data_d  = rsp_a_data_q;
        rsp_b_data_d  = rsp_b_data_q;
        if (gnt_a) begin
            last_d        = GNT_A;
            rsp_a_valid_d = 1'b1;
            rsp_a_data_d  = sbox_out;
        end else if (rsp_a_ready) begin
            rsp_a_valid_d = 1'b0;
        end
        if (gnt_b) begin
            last_d        = GNT_B;
            rsp_b_valid_d = 1'b1;
            rsp_b_data_d  = sbox_out[31:0];
        end else if (rsp_b_ready) begin
            rsp_b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_a_valid_q <= 1'b0;
            rsp_b_valid_q <= 1'b0;
            rsp_a_data_q  <= '0;
            rsp_b_data_q  <= '0;
            last_q        <= GNT_B;
            sel_q         <= GNT_A;
        end else begin
            rsp_a_valid_q <= rsp_a_valid_d;
            rsp_b_valid_q <= rsp_b_valid_d;
            rsp_a_data_q  <= rsp_a_data_d;
            rsp_b_data_q  <= rsp_b_data_d;
            last_q        <= last_d;
            sel_q         <= sel_d;
        end
    end

    assign rsp_a_valid = rsp_a_valid_q;
    assign rsp_b_valid = rsp_b_valid_q;
    assign rsp_a_data  = rsp_a_data_q;
    assign rsp_b_data  = rsp_b_data_q;

endmodule
